// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite response codes, splitter FSM state types and the default slave map.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {W_IDLE, W_ISSUE, W_WAIT, W_RESP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_t;

    localparam int DEF_NUM_SLAVES = 4;
    localparam logic [127:0] DEF_SLV_BASE = {32'h4000_3000, 32'h4000_2000,
                                             32'h4000_1000, 32'h4000_0000};
    localparam logic [127:0] DEF_SLV_MASK = {4{32'hFFFF_F000}};

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave index wins.
module axi_lite_addr_decode
    import axi_lite_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_W = 32,
    parameter int IDX_W = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = '0
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        idx = '0;
        // Scan downwards so a lower-index match overrides a higher one.
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                sel    = '0;
                sel[i] = 1'b1;
                hit    = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/axi_lite_xbar_1n.sv
// 1-to-N AXI-Lite splitter: independent write and read FSMs, one outstanding each,
// internal DECERR for unmapped addresses and SLVERR timeout with orphan draining.
module axi_lite_xbar_1n
    import axi_lite_pkg::*;
#(
    parameter int NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = DEF_SLV_MASK,
    parameter int TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ADDR_W-1:0]              s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_W-1:0]              s_axi_wdata,
    input  logic [DATA_W/8-1:0]            s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [1:0]                     s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_W-1:0]              s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_W-1:0]              s_axi_rdata,
    output logic [1:0]                     s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_SLAVES*ADDR_W-1:0]   m_axi_awaddr,
    output logic [NUM_SLAVES-1:0]          m_axi_awvalid,
    input  logic [NUM_SLAVES-1:0]          m_axi_awready,
    output logic [NUM_SLAVES*DATA_W-1:0]   m_axi_wdata,
    output logic [NUM_SLAVES*DATA_W/8-1:0] m_axi_wstrb,
    output logic [NUM_SLAVES-1:0]          m_axi_wvalid,
    input  logic [NUM_SLAVES-1:0]          m_axi_wready,
    input  logic [NUM_SLAVES*2-1:0]        m_axi_bresp,
    input  logic [NUM_SLAVES-1:0]          m_axi_bvalid,
    output logic [NUM_SLAVES-1:0]          m_axi_bready,
    output logic [NUM_SLAVES*ADDR_W-1:0]   m_axi_araddr,
    output logic [NUM_SLAVES-1:0]          m_axi_arvalid,
    input  logic [NUM_SLAVES-1:0]          m_axi_arready,
    input  logic [NUM_SLAVES*DATA_W-1:0]   m_axi_rdata,
    input  logic [NUM_SLAVES*2-1:0]        m_axi_rresp,
    input  logic [NUM_SLAVES-1:0]          m_axi_rvalid,
    output logic [NUM_SLAVES-1:0]          m_axi_rready,
    output logic [NUM_SLAVES-1:0]          orphan_w,
    output logic [NUM_SLAVES-1:0]          orphan_r
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [7:0] TMO = 8'(TIMEOUT);
    localparam bit TMO_EN = (TIMEOUT != 0);

    wr_state_t wstate, wstate_n;
    logic aw_held, aw_held_n, w_held, w_held_n, awready, awready_n, wready, wready_n;
    logic bvalid, bvalid_n;
    logic [1:0] bresp, bresp_n;
    logic [ADDR_W-1:0] aw_addr, aw_addr_n;
    logic [DATA_W-1:0] w_data, w_data_n;
    logic [STRB_W-1:0] w_strb, w_strb_n;
    logic [IDX_W-1:0] w_idx, w_idx_n, w_dec_idx;
    logic [NUM_SLAVES-1:0] awvalid, awvalid_n, wvalid, wvalid_n, bready, bready_n;
    logic [NUM_SLAVES-1:0] orph_w, orph_w_n, w_dec_sel;
    logic [7:0] w_cnt, w_cnt_n;
    logic w_hit, w_tmo, aw_fire, w_fire;
    logic [ADDR_W-1:0] w_dec_addr;

    rd_state_t rstate, rstate_n;
    logic ar_held, ar_held_n, arready, arready_n, rvalid, rvalid_n;
    logic [1:0] rresp, rresp_n;
    logic [ADDR_W-1:0] ar_addr, ar_addr_n, r_dec_addr;
    logic [DATA_W-1:0] rdata, rdata_n;
    logic [IDX_W-1:0] r_idx, r_idx_n, r_dec_idx;
    logic [NUM_SLAVES-1:0] arvalid, arvalid_n, rready, rready_n, orph_r, orph_r_n, r_dec_sel;
    logic [7:0] r_cnt, r_cnt_n;
    logic r_hit, r_tmo, ar_fire;

    // Once an address is held, decode the held copy; otherwise the one arriving now.
    assign w_dec_addr = aw_held ? aw_addr : s_axi_awaddr;
    assign r_dec_addr = ar_held ? ar_addr : s_axi_araddr;

    axi_lite_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                           .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
        u_wdec (.addr(w_dec_addr), .sel(w_dec_sel), .hit(w_hit), .idx(w_dec_idx));

    axi_lite_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .ADDR_W(ADDR_W), .IDX_W(IDX_W),
                           .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK))
        u_rdec (.addr(r_dec_addr), .sel(r_dec_sel), .hit(r_hit), .idx(r_dec_idx));

    assign aw_fire = s_axi_awvalid && awready;
    assign w_fire  = s_axi_wvalid && wready;
    assign ar_fire = s_axi_arvalid && arready;
    assign w_tmo   = TMO_EN && (w_cnt == TMO);
    assign r_tmo   = TMO_EN && (r_cnt == TMO);

    always_comb begin
        wstate_n = wstate;   aw_held_n = aw_held;   w_held_n = w_held;
        aw_addr_n = aw_addr; w_data_n = w_data;     w_strb_n = w_strb;
        w_idx_n = w_idx;     awvalid_n = awvalid;   wvalid_n = wvalid;
        bvalid_n = bvalid;   bresp_n = bresp;       w_cnt_n = w_cnt;
        // Any late response reaching an orphaned slot is swallowed and frees it.
        orph_w_n = orph_w & ~m_axi_bvalid;
        unique case (wstate)
            W_IDLE: begin
                if (aw_fire) aw_addr_n = s_axi_awaddr;
                if (w_fire) begin
                    w_data_n = s_axi_wdata;
                    w_strb_n = s_axi_wstrb;
                end
                aw_held_n = aw_held || aw_fire;
                w_held_n  = w_held || w_fire;
                if (aw_held_n && w_held_n) begin
                    if (!w_hit) begin
                        wstate_n = W_RESP; bvalid_n = 1'b1; bresp_n = RESP_DECERR;
                        aw_held_n = 1'b0;  w_held_n = 1'b0;
                    end else if (!orph_w[w_dec_idx]) begin
                        wstate_n = W_ISSUE; awvalid_n = w_dec_sel; wvalid_n = w_dec_sel;
                        w_idx_n = w_dec_idx; w_cnt_n = '0;
                        aw_held_n = 1'b0;    w_held_n = 1'b0;
                    end
                end
            end
            W_ISSUE: begin
                if (w_cnt != TMO) w_cnt_n = w_cnt + 8'd1;
                awvalid_n = awvalid & ~m_axi_awready;
                wvalid_n  = wvalid & ~m_axi_wready;
                if (awvalid_n == '0 && wvalid_n == '0) begin
                    if (w_tmo) begin
                        wstate_n = W_RESP; bvalid_n = 1'b1; bresp_n = RESP_SLVERR;
                        orph_w_n[w_idx] = 1'b1;
                    end else begin
                        wstate_n = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (w_cnt != TMO) w_cnt_n = w_cnt + 8'd1;
                if (m_axi_bvalid[w_idx]) begin
                    wstate_n = W_RESP; bvalid_n = 1'b1;
                    bresp_n = m_axi_bresp[2*int'(w_idx) +: 2];
                end else if (w_tmo) begin
                    wstate_n = W_RESP; bvalid_n = 1'b1; bresp_n = RESP_SLVERR;
                    orph_w_n[w_idx] = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    wstate_n = W_IDLE; bvalid_n = 1'b0;
                end
            end
            default: wstate_n = W_IDLE;
        endcase
        awready_n = (wstate_n == W_IDLE) && !aw_held_n;
        wready_n  = (wstate_n == W_IDLE) && !w_held_n;
        bready_n  = orph_w_n;
        if (wstate_n == W_WAIT) bready_n[w_idx_n] = 1'b1;
    end

    always_comb begin
        rstate_n = rstate;   ar_held_n = ar_held;   ar_addr_n = ar_addr;
        r_idx_n = r_idx;     arvalid_n = arvalid;   rvalid_n = rvalid;
        rresp_n = rresp;     rdata_n = rdata;       r_cnt_n = r_cnt;
        orph_r_n = orph_r & ~m_axi_rvalid;
        unique case (rstate)
            R_IDLE: begin
                if (ar_fire) ar_addr_n = s_axi_araddr;
                ar_held_n = ar_held || ar_fire;
                if (ar_held_n) begin
                    if (!r_hit) begin
                        rstate_n = R_RESP; rvalid_n = 1'b1; rresp_n = RESP_DECERR;
                        rdata_n = '0;      ar_held_n = 1'b0;
                    end else if (!orph_r[r_dec_idx]) begin
                        rstate_n = R_ISSUE; arvalid_n = r_dec_sel; r_idx_n = r_dec_idx;
                        r_cnt_n = '0;       ar_held_n = 1'b0;
                    end
                end
            end
            R_ISSUE: begin
                if (r_cnt != TMO) r_cnt_n = r_cnt + 8'd1;
                arvalid_n = arvalid & ~m_axi_arready;
                if (arvalid_n == '0) begin
                    if (r_tmo) begin
                        rstate_n = R_RESP; rvalid_n = 1'b1; rresp_n = RESP_SLVERR;
                        rdata_n = '0;      orph_r_n[r_idx] = 1'b1;
                    end else begin
                        rstate_n = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (r_cnt != TMO) r_cnt_n = r_cnt + 8'd1;
                if (m_axi_rvalid[r_idx]) begin
                    rstate_n = R_RESP; rvalid_n = 1'b1;
                    rresp_n = m_axi_rresp[2*int'(r_idx) +: 2];
                    rdata_n = m_axi_rdata[DATA_W*int'(r_idx) +: DATA_W];
                end else if (r_tmo) begin
                    rstate_n = R_RESP; rvalid_n = 1'b1; rresp_n = RESP_SLVERR;
                    rdata_n = '0;      orph_r_n[r_idx] = 1'b1;
                end
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    rstate_n = R_IDLE; rvalid_n = 1'b0;
                end
            end
            default: rstate_n = R_IDLE;
        endcase
        arready_n = (rstate_n == R_IDLE) && !ar_held_n;
        rready_n  = orph_r_n;
        if (rstate_n == R_WAIT) rready_n[r_idx_n] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;  aw_held <= 1'b0; w_held <= 1'b0; awready <= 1'b0;
            wready <= 1'b0;    bvalid <= 1'b0;  bresp <= '0;    aw_addr <= '0;
            w_data <= '0;      w_strb <= '0;    w_idx <= '0;    awvalid <= '0;
            wvalid <= '0;      bready <= '0;    orph_w <= '0;   w_cnt <= '0;
            rstate <= R_IDLE;  ar_held <= 1'b0; arready <= 1'b0; rvalid <= 1'b0;
            rresp <= '0;       rdata <= '0;     ar_addr <= '0;  r_idx <= '0;
            arvalid <= '0;     rready <= '0;    orph_r <= '0;   r_cnt <= '0;
        end else begin
            wstate <= wstate_n;   aw_held <= aw_held_n; w_held <= w_held_n;
            awready <= awready_n; wready <= wready_n;   bvalid <= bvalid_n;
            bresp <= bresp_n;     aw_addr <= aw_addr_n; w_data <= w_data_n;
            w_strb <= w_strb_n;   w_idx <= w_idx_n;     awvalid <= awvalid_n;
            wvalid <= wvalid_n;   bready <= bready_n;   orph_w <= orph_w_n;
            w_cnt <= w_cnt_n;
            rstate <= rstate_n;   ar_held <= ar_held_n; arready <= arready_n;
            rvalid <= rvalid_n;   rresp <= rresp_n;     rdata <= rdata_n;
            ar_addr <= ar_addr_n; r_idx <= r_idx_n;     arvalid <= arvalid_n;
            rready <= rready_n;   orph_r <= orph_r_n;   r_cnt <= r_cnt_n;
        end
    end

    assign s_axi_awready = awready;
    assign s_axi_wready  = wready;
    assign s_axi_bvalid  = bvalid;
    assign s_axi_bresp   = bresp;
    assign s_axi_arready = arready;
    assign s_axi_rvalid  = rvalid;
    assign s_axi_rresp   = rresp;
    assign s_axi_rdata   = rdata;
    assign m_axi_awaddr  = {NUM_SLAVES{aw_addr}};
    assign m_axi_wdata   = {NUM_SLAVES{w_data}};
    assign m_axi_wstrb   = {NUM_SLAVES{w_strb}};
    assign m_axi_araddr  = {NUM_SLAVES{ar_addr}};
    assign m_axi_awvalid = awvalid;
    assign m_axi_wvalid  = wvalid;
    assign m_axi_bready  = bready;
    assign m_axi_arvalid = arvalid;
    assign m_axi_rready  = rready;
    assign orphan_w      = orph_w;
    assign orphan_r      = orph_r;

endmodule

// File: tb/tb_axi_lite_xbar_1n.sv
// Directed bench for axi_lite_xbar_1n: 4 slaves, default map, TIMEOUT=8.
module tb_axi_lite_xbar_1n;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0]  s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0, s_axi_rdata;
    logic [3:0]   s_axi_wstrb = '0;
    logic         s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic         s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic         s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]   s_axi_bresp, s_axi_rresp;
    logic [127:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [127:0] m_axi_rdata = '0;
    logic [15:0]  m_axi_wstrb;
    logic [7:0]   m_axi_bresp = '0, m_axi_rresp = '0;
    logic [3:0]   m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [3:0]   m_axi_awready = '0, m_axi_wready = '0, m_axi_bvalid = '0;
    logic [3:0]   m_axi_arready = '0, m_axi_rvalid = '0;
    logic [3:0]   orphan_w, orphan_r;

    int total = 0;
    int bad = 0;
    int n;

    axi_lite_xbar_1n #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .orphan_w(orphan_w), .orphan_r(orphan_r)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        step(); step();
        check("rst_awready", s_axi_awready, 0);
        check("rst_bvalid", s_axi_bvalid, 0);
        check("rst_mvalid", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check("rst_mready", {m_axi_bready, m_axi_rready}, 0);
        rst = 1'b0;
        step();
        check("exit_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // W two cycles ahead of AW to slave 1
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h1234_5678; s_axi_wstrb = 4'hF;
        step();
        s_axi_wvalid = 1'b0;
        check("w_held_wready", s_axi_wready, 0);
        check("w_held_awready", s_axi_awready, 1);
        step();
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h4000_1004;
        step();
        s_axi_awvalid = 1'b0;
        check("wr1_awvalid", m_axi_awvalid, 4'b0010);
        check("wr1_wvalid", m_axi_wvalid, 4'b0010);
        check("wr1_awaddr", m_axi_awaddr[32 +: 32], 32'h4000_1004);
        check("wr1_wdata", m_axi_wdata[32 +: 32], 32'h1234_5678);
        check("wr1_wstrb", m_axi_wstrb[4 +: 4], 4'hF);
        m_axi_awready = 4'b0010; m_axi_wready = 4'b0010;
        step();
        m_axi_awready = '0; m_axi_wready = '0;
        check("wr1_valid_drop", {m_axi_awvalid, m_axi_wvalid}, 0);
        check("wr1_bready", m_axi_bready, 4'b0010);
        m_axi_bvalid = 4'b0010; m_axi_bresp = '0;
        step();
        m_axi_bvalid = '0;
        check("wr1_bvalid", s_axi_bvalid, 1);
        check("wr1_bresp", s_axi_bresp, 0);
        check("wr1_bready_off", m_axi_bready, 0);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check("wr1_done", {s_axi_bvalid, s_axi_awready}, 2'b01);

        // Read slave 2 with 3 wait cycles
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h4000_2010;
        step();
        s_axi_arvalid = 1'b0;
        check("rd_arvalid", m_axi_arvalid, 4'b0100);
        check("rd_araddr", m_axi_araddr[64 +: 32], 32'h4000_2010);
        m_axi_arready = 4'b0100;
        step();
        m_axi_arready = '0;
        check("rd_rready", m_axi_rready, 4'b0100);
        step(); step(); step();
        check("rd_no_early", s_axi_rvalid, 0);
        m_axi_rvalid = 4'b0100; m_axi_rdata[64 +: 32] = 32'hDEAD_BEEF; m_axi_rresp = '0;
        step();
        m_axi_rvalid = '0; m_axi_rdata = '0;
        check("rd_rvalid", s_axi_rvalid, 1);
        check("rd_rdata", s_axi_rdata, 32'hDEAD_BEEF);
        check("rd_rresp", s_axi_rresp, 0);
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        check("rd_done", s_axi_rvalid, 0);

        // Unmapped read and write
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h5000_0000;
        step();
        s_axi_arvalid = 1'b0;
        check("dec_rvalid", s_axi_rvalid, 1);
        check("dec_rresp", s_axi_rresp, 2'b11);
        check("dec_rdata", s_axi_rdata, 0);
        check("dec_arvalid", m_axi_arvalid, 0);
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h5000_0000; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("dec_bvalid", s_axi_bvalid, 1);
        check("dec_bresp", s_axi_bresp, 2'b11);
        check("dec_awvalid", m_axi_awvalid, 0);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;

        // Slave 3 withholds BVALID: timeout, orphan, stalled follow-up write
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h4000_3008; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("to_awvalid", m_axi_awvalid, 4'b1000);
        m_axi_awready = 4'b1000; m_axi_wready = 4'b1000;
        step();
        m_axi_awready = '0; m_axi_wready = '0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            step();
            n++;
        end
        check("to_latency", n, 8);
        check("to_bresp", s_axi_bresp, 2'b10);
        check("to_orphan", orphan_w, 4'b1000);
        check("to_drain_rdy", m_axi_bready, 4'b1000);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h4000_3010; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("stall_awready", s_axi_awready, 0);
        step(); step();
        check("stall_awvalid", m_axi_awvalid, 0);
        m_axi_bvalid = 4'b1000;
        step();
        m_axi_bvalid = '0;
        check("drain_bvalid", s_axi_bvalid, 0);
        check("drain_orphan", orphan_w, 0);
        step();
        check("resume_awvalid", m_axi_awvalid, 4'b1000);
        check("resume_awaddr", m_axi_awaddr[96 +: 32], 32'h4000_3010);
        m_axi_awready = 4'b1000; m_axi_wready = 4'b1000;
        step();
        m_axi_awready = '0; m_axi_wready = '0;
        m_axi_bvalid = 4'b1000;
        step();
        m_axi_bvalid = '0;
        check("resume_bresp", {s_axi_bvalid, s_axi_bresp}, 3'b100);
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;

        // Concurrent read and write to slave 0; B held under backpressure
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h4000_0004; s_axi_wvalid = 1'b1;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h4000_0000;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
        check("cc_valids", {m_axi_awvalid, m_axi_arvalid}, 8'b0001_0001);
        m_axi_awready = 4'b0001; m_axi_wready = 4'b0001; m_axi_arready = 4'b0001;
        step();
        m_axi_awready = '0; m_axi_wready = '0; m_axi_arready = '0;
        m_axi_bvalid = 4'b0001; m_axi_rvalid = 4'b0001; m_axi_rdata[31:0] = 32'hCAFE_0001;
        step();
        m_axi_bvalid = '0; m_axi_rvalid = '0; m_axi_rdata = '0;
        check("cc_r", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {3'b100, 32'hCAFE_0001});
        s_axi_rready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("cc_b_hold", {s_axi_bvalid, s_axi_bresp}, 3'b100);
            step();
            s_axi_rready = 1'b0;
        end
        s_axi_bready = 1'b1;
        step();
        s_axi_bready = 1'b0;
        check("cc_b_done", {s_axi_bvalid, s_axi_rvalid}, 0);

        // Read timeout leaves orphan_r, then reset in W_WAIT
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h4000_2000;
        step();
        s_axi_arvalid = 1'b0;
        m_axi_arready = 4'b0100;
        step();
        m_axi_arready = '0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin
            step();
            n++;
        end
        check("rto_resp", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {3'b110, 32'h0});
        check("rto_orphan", orphan_r, 4'b0100);
        s_axi_rready = 1'b1;
        step();
        s_axi_rready = 1'b0;
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h4000_1000; s_axi_wvalid = 1'b1;
        step();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        m_axi_awready = 4'b0010; m_axi_wready = 4'b0010;
        step();
        m_axi_awready = '0; m_axi_wready = '0;
        check("mr_in_wait", m_axi_bready, 4'b0010);
        rst = 1'b1;
        step();
        check("mr_outs", {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid,
                          s_axi_rvalid, s_axi_bresp, s_axi_rresp}, 0);
        check("mr_m", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready}, 0);
        check("mr_orphans", {orphan_w, orphan_r}, 0);
        rst = 1'b0;
        step();
        check("mr_exit_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
